// File: rtl/pc_sequencer.sv
// Fetch program counter: stall, branch/jump redirect, call/return through a circular return-address stack.
// Optional macro PC_ALIGN_CHECK_EN adds AlignFault and suppresses PC updates to misaligned redirect targets.
module pc_sequencer #(
    parameter int WIDTH     = 32,
    parameter int INC       = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           MasterReset,
    input  logic [WIDTH-1:0]               StartPC,
    input  logic                           Stall,
    input  logic                           BranchTaken,
    input  logic [WIDTH-1:0]               BranchTarget,
    input  logic                           Jump,
    input  logic                           Call,
    input  logic [WIDTH-1:0]               JumpTarget,
    input  logic                           Return,
    output logic [WIDTH-1:0]               PC,
    output logic [$clog2(RAS_DEPTH+1)-1:0] RasCount,
    output logic                           RasOverflow,
    output logic                           RasUnderflow
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                           AlignFault
`endif
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
`endif

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
`ifdef PC_ALIGN_CHECK_EN
    logic             af_q, af_d;
`endif

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] redir_tgt;
    logic             redir;
    logic [PTR_W-1:0] top_next;
    logic [PTR_W-1:0] top_prev;

    assign pc_inc   = pc_q + WIDTH'(INC);
    assign top_next = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + 1'b1;
    assign top_prev = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - 1'b1;

    always_comb begin
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        top_d     = top_q;
        ras_d     = ras_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        redir     = 1'b0;
        redir_tgt = pc_inc;
`ifdef PC_ALIGN_CHECK_EN
        af_d      = 1'b0;
`endif
        if (!Stall) begin
            if (Return) begin
                if (cnt_q != '0) begin
                    redir     = 1'b1;
                    redir_tgt = ras_q[top_q];
                    top_d     = top_prev;
                    cnt_d     = cnt_q - 1'b1;
                end else begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end
            end else if (Call) begin
                // A full stack overwrites the oldest slot simply by advancing the top pointer around.
                ras_d[top_next] = pc_inc;
                top_d           = top_next;
                if (cnt_q == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
                else                            cnt_d = cnt_q + 1'b1;
                redir     = 1'b1;
                redir_tgt = JumpTarget;
            end else if (Jump) begin
                redir     = 1'b1;
                redir_tgt = JumpTarget;
            end else if (BranchTaken) begin
                redir     = 1'b1;
                redir_tgt = BranchTarget;
            end else begin
                pc_d = pc_inc;
            end

            if (redir) begin
`ifdef PC_ALIGN_CHECK_EN
                if ((redir_tgt & ALIGN_MASK) != '0) af_d = 1'b1;
                else                                pc_d = redir_tgt;
`else
                pc_d = redir_tgt;
`endif
            end
        end
    end

    always_ff @(negedge CLK) begin
        if (MasterReset) begin
            pc_q  <= StartPC;
            cnt_q <= '0;
            top_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            af_q  <= 1'b0;
`endif
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            top_q <= top_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
`ifdef PC_ALIGN_CHECK_EN
            af_q  <= af_d;
`endif
        end
    end

    // Stack contents are don't-care after reset; only the count and pointer are cleared.
    always_ff @(negedge CLK) begin
        ras_q <= ras_d;
    end

    assign PC           = pc_q;
    assign RasCount     = cnt_q;
    assign RasOverflow  = ovf_q;
    assign RasUnderflow = unf_q;
`ifdef PC_ALIGN_CHECK_EN
    assign AlignFault   = af_q;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the single-cycle datapath.
- Adds width/increment generalisation, stall, branch and jump redirect, call/return via an internal return-address stack (RAS).
- Sits at the head of instruction fetch; PC output feeds instruction memory address directly.

Parameters:
- WIDTH, 32, bit width of all address ports and the PC register.
- INC, 4, byte increment per sequential fetch; must be a power of two.
- RAS_DEPTH, 4, number of return-address stack entries; must be ≥ 1.

Ports:
- CLK  input  1  clock; all state updates on negedge CLK.
- MasterReset  input  1  synchronous, active-high reset, sampled on negedge CLK.
- StartPC  input  WIDTH  address loaded into PC on reset.
- Stall  input  1  hold PC and RAS unchanged this cycle.
- BranchTaken  input  1  redirect to BranchTarget.
- BranchTarget  input  WIDTH  branch destination.
- Jump  input  1  redirect to JumpTarget.
- Call  input  1  push PC+INC onto RAS, redirect to JumpTarget.
- JumpTarget  input  WIDTH  jump/call destination.
- Return  input  1  pop RAS top into PC.
- PC  output  WIDTH  current fetch address.
- RasCount  output  $clog2(RAS_DEPTH+1)  valid RAS entries.
- RasOverflow  output  1  one-cycle pulse: push discarded oldest entry.
- RasUnderflow  output  1  one-cycle pulse: Return with empty RAS.

Behaviour:
- Reset, when MasterReset=1 at a negedge:
  - PC=StartPC, RasCount=0, RasOverflow=0, RasUnderflow=0.
  - RAS contents are don't-care.
  - Reset overrides every other input, including mid-call sequences.
- The first fetch after reset is StartPC itself; no StartPC−INC pre-bias.
- Next-state priority per negedge, highest first:
  - 1 reset
  - 2 Stall: PC, RAS, RasCount held; pulses cleared.
  - 3 Return
  - 4 Call
  - 5 Jump
  - 6 BranchTaken
  - 7 sequential: PC=PC+INC.
- Return, RasCount>0: PC=RAS top, RasCount decrements.
- Return, RasCount=0: PC=PC+INC, RasUnderflow=1 for one cycle.
- Call: push PC+INC, PC=JumpTarget.
  - RasCount<RAS_DEPTH: RasCount increments.
  - RasCount=RAS_DEPTH: oldest entry discarded (circular), RasCount stays RAS_DEPTH, RasOverflow=1 for one cycle.
- Call and Return together: Return wins, Call ignored (no push).
- Jump and BranchTaken together: Jump wins.
- Arithmetic is modulo 2^WIDTH. PC+INC wraps from all-ones-region to 0 silently; pushed return address wraps identically.
- Latency: redirect inputs sampled at negedge N appear on PC immediately after negedge N (one edge).
- Pulse outputs are registered, valid for exactly the cycle following the causing edge; otherwise 0.
- RAS implemented as circular buffer with top pointer; no combinational path from inputs to PC.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - adds output AlignFault (1 bit, reset 0).
  - Any redirect whose selected target has a nonzero value in bits [$clog2(INC)-1:0] does not update PC; the PC holds, the RAS still performs its push/pop, and AlignFault=1 for one cycle.
  - INC=1 disables the check.
- Undefined: port absent; targets are loaded unmodified.

Test Plan:
- Reset: StartPC=0x00400000, MasterReset=1 for 2 edges, then 0 → PC=0x00400000, then 0x00400004, 0x00400008.
- Stall: PC=0x100, Stall=1 for 3 edges → PC stays 0x100; next edge with Stall=0 → 0x104.
- Call/return: PC=0x200, Call with JumpTarget=0x800 → PC=0x800, RasCount=1; two sequential edges → 0x808; Return → PC=0x204, RasCount=0.
- RAS overflow: RAS_DEPTH=4, five nested Calls from 0x10,0x20,0x30,0x40,0x50 → RasOverflow pulses on fifth, RasCount=4; four Returns → 0x54,0x44,0x34,0x24; fifth Return → RasUnderflow=1, PC=prev+4.
- Priority/wrap: WIDTH=32, PC=0xFFFFFFFC sequential → PC=0x00000000. Jump=1 with BranchTaken=1 → PC=JumpTarget. Call+Return with empty RAS → RasUnderflow=1, RasCount stays 0.
- With PC_ALIGN_CHECK_EN: Jump to 0x1002 from PC=0x300 → PC stays 0x300, AlignFault=1 one cycle; Jump to 0x1004 → PC=0x1004.
